xbar_out_port: RTL
==================

# xbar_out_port

Output-port stage of the stream crossbar: collects up to four input streams contending for one output, picks a winner with `fixed_prio_arb` (request 0 highest), holds that grant for a whole packet, and drives the selected beats into a registered output stream. It sits directly downstream of the arbiter. It turns the arbiter's single-cycle combinational grant into a packet-locked, valid/ready-compliant data path.

## Interface
- `NUM_REQUEST`, default 4: number of input streams. Must be 4, matching the arbiter's grant equations.
- `DATA_WIDTH`, default 32: beat width in bits.
- `CNT_WIDTH`, default 16: width of the completed-packet counter.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `s_valid_i`  in  NUM_REQUEST  per-input beat valid.
- `s_data_i`  in  NUM_REQUEST*DATA_WIDTH  input beats; input k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `s_last_i`  in  NUM_REQUEST  per-input end-of-packet marker.
- `s_ready_o`  out  NUM_REQUEST  per-input ready; one-hot or zero.
- `m_valid_o`  out  1  output beat valid (registered).
- `m_data_o`  out  DATA_WIDTH  output beat (registered).
- `m_last_o`  out  1  output end-of-packet marker (registered).
- `m_ready_i`  in  1  downstream ready.
- `sel_o`  out  NUM_REQUEST  currently locked grant; one-hot, or zero when idle.
- `pkt_cnt_o`  out  CNT_WIDTH  count of packets fully accepted into the output register.

## Operation
- The FSM has two states, IDLE and LOCKED.
- IDLE:
  - `s_ready_o` = 0.
  - The arbiter is fed `s_valid_i`.
  - If any `s_valid_i` bit is high, `sel_q` takes the arbiter grant and the state moves to LOCKED.
  - Otherwise the block stays in IDLE.
- LOCKED:
  - The arbiter output is ignored; `sel_q` is held.
  - The selected input k sees `s_ready_o[k] = out_free`, where `out_free = !m_valid_o | m_ready_i`. All other ready bits are 0.
  - An input beat is accepted when `s_valid_i[k] & s_ready_o[k]`. On acceptance the output register loads `s_data_i[k]` and `s_last_i[k]`, and `m_valid_o` becomes 1.
  - If the accepted beat has last set: the state returns to IDLE, `sel_q` clears to 0, and `pkt_cnt_o` increments.
- Output register:
  - If `m_valid_o & m_ready_i` and no new beat is loaded in the same cycle, `m_valid_o` clears.
  - A simultaneous drain and load keeps `m_valid_o` at 1 with the new beat.
  - `m_data_o` and `m_last_o` hold while `m_valid_o & !m_ready_i`.
- Requests from non-selected inputs arriving mid-packet are ignored until IDLE. Their data must be held by the source (standard valid/ready).
- A deasserted `s_valid_i[k]` mid-packet inserts bubbles; the lock is kept, with no timeout.
- `pkt_cnt_o` wraps from 2^CNT_WIDTH-1 to 0.
- `sel_o` = `sel_q`.

## Timing
- All outputs are 0 during reset: `s_ready_o`, `m_valid_o`, `m_data_o`, `m_last_o`, `sel_o`, `pkt_cnt_o`. The state resets to IDLE.
- Reset asserted mid-packet drops the packet immediately. The output register is cleared even if `m_valid_o & !m_ready_i`. There is no partial-packet recovery.
- Arbitration latency is 1 cycle. If a valid first appears in cycle T, in IDLE, then `s_ready_o[k]` can be 1 in cycle T+1. The first beat is visible on `m_valid_o` in T+2.
- Within a packet, throughput is 1 beat/cycle with `m_ready_i` held high.
- Between packets there is exactly one dead cycle (the IDLE arbitration cycle), even when requests are continuous.
- A single-beat packet (last on the first beat) takes LOCKED for one cycle, then IDLE.
- Back-pressure: with `m_valid_o=1` and `m_ready_i=0`, `s_ready_o` = 0 in the same cycle (combinational from `m_ready_i`). There is no path from `s_valid_i` to `s_ready_o`.
- Simultaneous requests in IDLE resolve by the fixed priority 0 > 1 > 2 > 3. A lower-priority input can starve; this is accepted.

## Test plan
- **Single packet:** only input 2 sends 3 beats 0xA0, 0xA1, 0xA2, with last on 0xA2, starting cycle 0, and `m_ready_i`=1.
  - Required: `sel_o`=4'b0100 from cycle 1; `m_data_o` = A0, A1, A2 in cycles 2-4; `m_last_o` only in cycle 4.
  - Required: `pkt_cnt_o`=1 and `sel_o`=0 from cycle 4.
- **Contention:** inputs 1 and 3 both valid in cycle 0 with 2-beat packets.
  - Required: input 1's packet is transferred first; input 3 is granted only after the one-cycle IDLE gap.
  - Required: no interleaving of beats.
- **Late arrival mid-packet:** input 0 asserts valid while input 2 is locked.
  - Required: input 2's packet completes intact, then input 0 wins the next arbitration.
- **Back-pressure:** `m_ready_i`=0 for 3 cycles during a packet.
  - Required: `m_data_o` is stable; `s_ready_o`=0; no beat is lost or duplicated once `m_ready_i` returns.
- **Reset and counter wrap:** assert `rst_i` after 1 of 4 beats.
  - Required: all outputs are 0 on the next cycle and the state is IDLE.
  - Counter wrap, separately: with CNT_WIDTH=2, after 5 packets `pkt_cnt_o`=1.

Source files
------------

// File: rtl/xbar_out_port.sv
// -----------------------------------------------------------------------------
// xbar_out_port
//
// Output-port stage of the stream crossbar. Up to four input streams compete
// for one output. A fixed-priority arbiter picks a winner (request 0 has the
// highest priority). The grant is then held for the whole packet, and the
// selected beats go into a registered valid/ready output stage.
//
// fixed_prio_arb : combinational 4-way fixed-priority arbiter (req 0 highest).
//   req  in  4   request vector
//   gnt  out 4   one-hot grant, or zero when there is no request
//
// xbar_out_port ports:
//   clk_i      in   1                      rising-edge clock
//   rst_i      in   1                      synchronous active-high reset
//   s_valid_i  in   NUM_REQUEST            per-input beat valid
//   s_data_i   in   NUM_REQUEST*DATA_WIDTH input k at [k*DATA_WIDTH +: DATA_WIDTH]
//   s_last_i   in   NUM_REQUEST            per-input end-of-packet
//   s_ready_o  out  NUM_REQUEST            per-input ready (one-hot or zero)
//   m_valid_o  out  1                      registered output valid
//   m_data_o   out  DATA_WIDTH             registered output beat
//   m_last_o   out  1                      registered output end-of-packet
//   m_ready_i  in   1                      downstream ready
//   sel_o      out  NUM_REQUEST            locked grant (zero when idle)
//   pkt_cnt_o  out  CNT_WIDTH              packets fully accepted (wraps)
// -----------------------------------------------------------------------------

module fixed_prio_arb (
  input  logic [3:0] req,
  output logic [3:0] gnt
);
  assign gnt[0] = req[0];
  assign gnt[1] = req[1] & ~req[0];
  assign gnt[2] = req[2] & ~req[1] & ~req[0];
  assign gnt[3] = req[3] & ~req[2] & ~req[1] & ~req[0];
endmodule

module xbar_out_port #(
  parameter int NUM_REQUEST = 4,   // the arbiter equations are written for exactly 4
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_REQUEST-1:0]            s_valid_i,
  input  logic [NUM_REQUEST*DATA_WIDTH-1:0] s_data_i,
  input  logic [NUM_REQUEST-1:0]            s_last_i,
  output logic [NUM_REQUEST-1:0]            s_ready_o,
  output logic                              m_valid_o,
  output logic [DATA_WIDTH-1:0]             m_data_o,
  output logic                              m_last_o,
  input  logic                              m_ready_i,
  output logic [NUM_REQUEST-1:0]            sel_o,
  output logic [CNT_WIDTH-1:0]              pkt_cnt_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                   state_reg, state_next;
  logic [NUM_REQUEST-1:0]   sel_reg, sel_next;
  logic                     m_valid_reg;
  logic [DATA_WIDTH-1:0]    m_data_reg;
  logic                     m_last_reg;
  logic [CNT_WIDTH-1:0]     pkt_cnt_reg;

  logic [NUM_REQUEST-1:0]   gnt;
  logic                     out_free;
  logic [NUM_REQUEST-1:0]   accept_vec;
  logic                     accept;
  logic                     pkt_done;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic                     sel_last;
  logic [DATA_WIDTH-1:0]    masked_data [NUM_REQUEST];

  fixed_prio_arb u_arb (
    .req (s_valid_i),
    .gnt (gnt)
  );

  // The output register can take a beat when it is empty or draining this cycle.
  assign out_free = !m_valid_reg | m_ready_i;

  // Ready comes only from state and m_ready_i, never from s_valid_i. Gating it
  // with reset keeps every output at zero while reset is held.
  assign s_ready_o  = (state_reg == LOCKED && !rst_i) ? (sel_reg & {NUM_REQUEST{out_free}})
                                                      : '0;
  assign accept_vec = s_valid_i & s_ready_o;
  assign accept     = |accept_vec;

  // One-hot AND-OR mux driven by the locked grant.
  generate
    for (genvar gi = 0; gi < NUM_REQUEST; gi++) begin : g_mask
      assign masked_data[gi] = {DATA_WIDTH{sel_reg[gi]}} & s_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQUEST; i++) begin
      sel_data = sel_data | masked_data[i];
    end
  end

  assign sel_last = |(s_last_i & sel_reg);
  assign pkt_done = accept & sel_last;

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    case (state_reg)
      IDLE: begin
        if (|s_valid_i) begin
          sel_next   = gnt;
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (pkt_done) begin
          sel_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        sel_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      sel_reg     <= '0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_last_reg  <= 1'b0;
      pkt_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      if (accept) begin
        // A load takes priority over a drain, so a drain and a load in the
        // same cycle leave valid high with the new beat.
        m_valid_reg <= 1'b1;
        m_data_reg  <= sel_data;
        m_last_reg  <= sel_last;
      end else if (m_ready_i) begin
        m_valid_reg <= 1'b0;
      end
      if (pkt_done) begin
        pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
      end
    end
  end

  assign m_valid_o = m_valid_reg;
  assign m_data_o  = m_data_reg;
  assign m_last_o  = m_last_reg;
  assign sel_o     = sel_reg;
  assign pkt_cnt_o = pkt_cnt_reg;

endmodule
